// File: rtl/cvm_param.sv
// cvm_param: coin-operated vending controller with parameterised price.
//
// Coins and the cancel button arrive as raw levels. Each one passes through
// a small edge detector that emits a single-cycle event once the input has
// been seen high and then low. The main FSM adds up credit, dispenses an
// item once the price is reached, and hands back change or refunds credit
// as a train of dime/nickel pulses separated by GAP idle cycles.
//
// Parameters
//   PRICE_N   item price in nickels (1..31)
//   CREDIT_W  credit register width, must hold PRICE_N+7
//   GAP       idle cycles between successive change/refund pulses
//
// Ports
//   clk         rising-edge clock
//   rst_        asynchronous active-low reset
//   n_raw       raw nickel slot level
//   d_raw       raw dime slot level
//   q_raw       raw quarter slot level
//   cancel_raw  raw cancel button level
//   del         one-cycle item-dispense pulse
//   rn          one-cycle nickel return pulse
//   rd          one-cycle dime return pulse
//   busy        high while vending, giving change or refunding
//   credit      current credit in nickels

// CvmEdgeDet: three-state release detector for one raw input.
//   clk, rst_  clock and asynchronous active-low reset
//   raw_i      raw level
//   evt_o      high for exactly one cycle after a captured high is released
module CvmEdgeDet (
    input  logic clk,
    input  logic rst_,
    input  logic raw_i,
    output logic evt_o
);

    typedef enum logic [1:0] {
        DET_IDLE,
        DET_HIGH,
        DET_FALL
    } det_state_e;

    det_state_e state_q;

    // A level held for many cycles parks in HIGH, so only its release
    // produces an event; a new press during FALL goes straight back to HIGH.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= DET_IDLE;
        end else begin
            case (state_q)
                DET_IDLE: state_q <= raw_i ? DET_HIGH : DET_IDLE;
                DET_HIGH: state_q <= raw_i ? DET_HIGH : DET_FALL;
                DET_FALL: state_q <= raw_i ? DET_HIGH : DET_IDLE;
                default:  state_q <= DET_IDLE;
            endcase
        end
    end

    assign evt_o = (state_q == DET_FALL);

endmodule

module cvm_param #(
    parameter int PRICE_N  = 5,
    parameter int CREDIT_W = 6,
    parameter int GAP      = 1
) (
    input  logic                clk,
    input  logic                rst_,
    input  logic                n_raw,
    input  logic                d_raw,
    input  logic                q_raw,
    input  logic                cancel_raw,
    output logic                del,
    output logic                rn,
    output logic                rd,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE_N);
    localparam logic [GAP_W-1:0]    GAP_C   = GAP_W'(GAP);

    typedef enum logic [1:0] {
        ACCEPT,
        VEND,
        CHANGE,
        REFUND
    } main_state_e;

    logic nEvt, dEvt, qEvt, cEvt;

    CvmEdgeDet uNickel (.clk(clk), .rst_(rst_), .raw_i(n_raw),      .evt_o(nEvt));
    CvmEdgeDet uDime   (.clk(clk), .rst_(rst_), .raw_i(d_raw),      .evt_o(dEvt));
    CvmEdgeDet uQuart  (.clk(clk), .rst_(rst_), .raw_i(q_raw),      .evt_o(qEvt));
    CvmEdgeDet uCancel (.clk(clk), .rst_(rst_), .raw_i(cancel_raw), .evt_o(cEvt));

    main_state_e         state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [CREDIT_W-1:0] sum;
    logic                del_q, rn_q, rd_q, busy_q;
    logic                pulseNext;

    // Next-state logic. Events are only looked at in ACCEPT, so anything that
    // arrives while busy simply evaporates. In CHANGE/REFUND a zero gap
    // counter marks a pulse cycle; the gap is reloaded after each pulse unless
    // the credit has just run out, in which case we return to ACCEPT at once.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        gap_d    = gap_q;
        sum      = credit_q + CREDIT_W'(nEvt)
                 + (dEvt ? CREDIT_W'(2) : '0)
                 + (qEvt ? CREDIT_W'(5) : '0);
        case (state_q)
            ACCEPT: begin
                credit_d = sum;
                gap_d    = '0;
                if (sum >= PRICE_C) begin
                    state_d = VEND;
                end else if (cEvt && (sum != '0)) begin
                    state_d = REFUND;
                end
            end
            VEND: begin
                credit_d = credit_q - PRICE_C;
                gap_d    = '0;
                state_d  = (credit_d != '0) ? CHANGE : ACCEPT;
            end
            CHANGE, REFUND: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GAP_W'(1);
                end else begin
                    credit_d = credit_q - ((credit_q >= CREDIT_W'(2)) ? CREDIT_W'(2) : CREDIT_W'(1));
                    if (credit_d == '0) begin
                        state_d = ACCEPT;
                        gap_d   = '0;
                    end else begin
                        gap_d = GAP_C;
                    end
                end
            end
            default: begin
                state_d = ACCEPT;
            end
        endcase
    end

    // Outputs are registered alongside the state they decode, so del/rn/rd
    // are a pure function of the registered state and credit.
    assign pulseNext = ((state_d == CHANGE) || (state_d == REFUND)) && (gap_d == '0);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q  <= ACCEPT;
            credit_q <= '0;
            gap_q    <= '0;
            del_q    <= 1'b0;
            rn_q     <= 1'b0;
            rd_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            gap_q    <= gap_d;
            del_q    <= (state_d == VEND);
            rd_q     <= pulseNext && (credit_d >= CREDIT_W'(2));
            rn_q     <= pulseNext && (credit_d <  CREDIT_W'(2));
            busy_q   <= (state_d != ACCEPT);
        end
    end

    assign del    = del_q;
    assign rn     = rn_q;
    assign rd     = rd_q;
    assign busy   = busy_q;
    assign credit = credit_q;

endmodule

// File: doc/cvm_param.md
CVM_PARAM -- requirements
Module: cvm_param

Interface
REQ-001 Parameter PRICE_N, default 5, item price in nickel units (5 = 25 cents); legal range 1..31.
REQ-002 Parameter CREDIT_W, default 6, credit register width; SHALL hold PRICE_N+7 without overflow.
REQ-003 Parameter GAP, default 1, number of idle cycles between successive change/refund pulses; 0 means back-to-back.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_  input  1  asynchronous active-low reset.
REQ-006 n_raw, d_raw, q_raw  input  1 each  raw coin-slot levels for nickel, dime and quarter, high for one or more cycles per coin.
REQ-007 cancel_raw  input  1  raw cancel-button level, same pulse form as coins.
REQ-008 del  output  1  one-cycle item-dispense pulse.
REQ-009 rn / rd  output  1 each  one-cycle nickel / dime return pulses.
REQ-010 busy  output  1  high in VEND, CHANGE and REFUND.
REQ-011 credit  output  CREDIT_W  current credit in nickels.

Function
REQ-012 Each raw input SHALL pass through a 3-state edge detector (IDLE, HIGH, FALL): IDLE->HIGH on raw=1; HIGH holds while raw=1; HIGH->FALL on raw=0; FALL->HIGH on raw=1, else IDLE.
REQ-013 The detector event SHALL be high exactly one cycle (state FALL), i.e. the cycle after the first edge sampling raw=0 following >=1 edge sampling raw=1; a raw high not captured at any rising edge SHALL produce no event.
REQ-014 A raw input held high any number of cycles SHALL produce exactly one event after release.
REQ-015 Main FSM states: ACCEPT, VEND, CHANGE, REFUND; the main FSM and all detectors reset into ACCEPT and IDLE respectively.
REQ-016 ACCEPT: sum = credit + 1*n + 2*d + 5*q over all simultaneous events; credit <= sum at the clock edge.
REQ-017 ACCEPT: if sum >= PRICE_N, next state is VEND, and cancel is ignored.
REQ-018 ACCEPT: else if the cancel event is high and sum > 0, next state is REFUND.
REQ-019 ACCEPT: a cancel event with sum = 0 SHALL be ignored.
REQ-020 VEND (exactly one cycle): del=1; credit <= credit - PRICE_N; next state is CHANGE if the result is > 0, else ACCEPT.
REQ-021 CHANGE and REFUND: on a pulse cycle, rd=1 and credit -= 2 if credit >= 2, else rn=1 and credit -= 1.
REQ-022 CHANGE and REFUND: after each pulse, GAP cycles with rn=rd=0 SHALL follow, using a gap counter; when credit reaches 0 the FSM SHALL return to ACCEPT immediately with no trailing gap.
REQ-023 rn and rd SHALL never be high in the same cycle; del SHALL never coincide with rn or rd.
REQ-024 Coin and cancel events arriving while busy=1 SHALL be discarded; credit is unaffected.
REQ-025 Latency: event in cycle t -> credit updated and del high in cycle t+1 -> first change pulse in cycle t+2.
REQ-026 Outputs del, rn and rd SHALL be decoded from registered state only (Moore); busy SHALL be high exactly when the state is not ACCEPT.

Reset
REQ-027 rst_=0 SHALL immediately force del=rn=rd=busy=0, credit=0, main FSM to ACCEPT, detectors to IDLE and the gap counter to 0, regardless of clk.
REQ-028 Reset asserted mid-CHANGE or mid-REFUND SHALL abandon the remaining change; no pulse SHALL appear after deassertion without new events.
REQ-029 The first rising edge after rst_ deasserts SHALL operate normally; a raw input already high at deassertion counts as one coin after it falls.

Verification (PRICE_N=5, GAP=1)
REQ-030 Five nickel raw pulses of 7 cycles each -> credit 1,2,3,4 then del one cycle after the 5th event; no rn/rd; credit returns to 0.
REQ-031 Four nickels then one quarter (sum 9) -> del; credit 4; then rd, gap, rd; ACCEPT; exactly two rd pulses.
REQ-032 Dime, nickel, cancel -> REFUND of 3: rd, one idle cycle, rn; credit 0; del never asserted.
REQ-033 d_raw and q_raw released on the same edge at credit 0 -> sum 7 -> del, then one rd; cancel in that same cycle ignored.
REQ-034 n_raw held high 20 cycles -> exactly one nickel event after release; a 1 ns n_raw glitch between edges -> no credit change.
REQ-035 Quarter event during CHANGE -> discarded, busy=1, change sequence unchanged; rst_ pulled low mid-CHANGE -> all outputs 0 at once, credit 0, no later pulses.
